// File: rtl/dw_bn_act_engine.sv
// Channel-interleaved depthwise 3x3 convolution with per-channel BN, selectable
// activation and valid/ready flow control; four-stage pipeline that stalls as a whole.
module dw_bn_act_engine #(
    parameter int int_bits  = 13,
    parameter int frac_bits = 8,
    parameter int CH        = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [3*int_bits-1:0]                in_g,
    input  logic                                 in_sol,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [1:0]                           act_mode,
    input  logic                                 cfg_we,
    input  logic [$clog2(CH)+3:0]                cfg_addr,
    input  logic [int_bits-1:0]                  cfg_data,
    output logic [int_bits-1:0]                  out_data,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int DW = int_bits;
    localparam int PW = 2 * DW;
    localparam int SW = PW + 4;
    localparam int BW = PW + 1;

    typedef logic signed [DW-1:0] word_t;
    typedef logic [3*DW-1:0]      col_t;

    localparam word_t                D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam word_t                D_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [SW-1:0] S_MAX = SW'(D_MAX);
    localparam logic signed [SW-1:0] S_MIN = SW'(D_MIN);
    localparam logic signed [BW-1:0] B_MAX = BW'(D_MAX);
    localparam logic signed [BW-1:0] B_MIN = BW'(D_MIN);
    localparam logic signed [PW-1:0] R6_W  = PW'(6) <<< frac_bits;
    localparam logic signed [PW-1:0] DMAX_W = PW'(D_MAX);
    localparam word_t                CAP   = (R6_W > DMAX_W) ? D_MAX : R6_W[DW-1:0];

    word_t wgt   [CH][9];
    word_t scale [CH];
    word_t bias  [CH];
    col_t  hist0 [CH];
    col_t  hist1 [CH];

    logic [CW-1:0] ch_cnt;
    logic [1:0]    col_cnt;

    logic          stall, accept, produce, last_ch;
    logic [CW-1:0] cur_ch, cfg_ch;
    logic [1:0]    cur_col;
    logic [3:0]    cfg_slot;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !cfg_we;
    assign accept   = in_valid && in_ready;

    // in_sol overrides the running counters so a drifted stream realigns on this beat
    assign cur_ch   = in_sol ? '0 : ch_cnt;
    assign cur_col  = in_sol ? 2'd0 : col_cnt;
    assign produce  = (cur_col == 2'd2);
    assign last_ch  = (cur_ch == CW'(CH - 1));
    assign cfg_slot = cfg_addr[3:0];

    generate
        if (CH > 1) begin : g_cfg_ch
            assign cfg_ch = cfg_addr[CW+3:4];
        end else begin : g_cfg_ch0
            assign cfg_ch = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CH; i++) begin
                for (int unsigned j = 0; j < 9; j++) wgt[i][j] <= '0;
                scale[i] <= '0;
                bias[i]  <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < CH)) begin
            if (cfg_slot < 4'd9)       wgt[cfg_ch][cfg_slot] <= cfg_data;
            else if (cfg_slot == 4'd9)  scale[cfg_ch] <= cfg_data;
            else if (cfg_slot == 4'd10) bias[cfg_ch]  <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                hist0[i] <= '0;
                hist1[i] <= '0;
            end
        end else if (accept) begin
            hist1[cur_ch] <= hist0[cur_ch];
            hist0[cur_ch] <= in_g;
            if (last_ch) begin
                ch_cnt  <= '0;
                col_cnt <= (cur_col == 2'd2) ? 2'd2 : cur_col + 2'd1;
            end else begin
                ch_cnt  <= cur_ch + 1'b1;
                col_cnt <= cur_col;
            end
        end
    end

    // Column 0 is the oldest column of the window, column 2 the incoming one
    col_t                  cols [3];
    logic signed [PW-1:0]  prod_c [9];

    always_comb begin
        cols[0] = hist1[cur_ch];
        cols[1] = hist0[cur_ch];
        cols[2] = in_g;
        for (int unsigned r = 0; r < 3; r++)
            for (int unsigned c = 0; c < 3; c++)
                prod_c[r*3+c] = word_t'(cols[c][r*DW +: DW]) * wgt[cur_ch][r*3+c];
    end

    logic signed [PW-1:0] s1_prod [9];
    logic                 s1_v, s2_v, s3_v;
    logic [CW-1:0]        s1_ch, s2_ch, s3_ch;
    logic [1:0]           s1_mode, s2_mode, s3_mode;
    word_t                s2_val;
    logic signed [PW-1:0] s3_val;

    logic signed [SW-1:0] sum, sum_sh;
    word_t                s2_c;
    logic signed [PW-1:0] bn_prod, s3_c;
    logic signed [BW-1:0] bsum;
    word_t                bsat, act;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 9; i++) sum = sum + s1_prod[i];
        sum_sh = sum >>> frac_bits;
        if (sum_sh > S_MAX)      s2_c = D_MAX;
        else if (sum_sh < S_MIN) s2_c = D_MIN;
        else                     s2_c = sum_sh[DW-1:0];
    end

    always_comb begin
        bn_prod = s2_val * scale[s2_ch];
        s3_c    = bn_prod >>> frac_bits;
    end

    always_comb begin
        bsum = s3_val + bias[s3_ch];
        if (bsum > B_MAX)      bsat = D_MAX;
        else if (bsum < B_MIN) bsat = D_MIN;
        else                   bsat = bsum[DW-1:0];
        case (s3_mode)
            2'd0:    act = bsat;
            2'd2:    act = (bsat < 0) ? '0 : ((bsat > CAP) ? CAP : bsat);
            default: act = (bsat < 0) ? '0 : bsat;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s3_v      <= 1'b0;
            s1_ch     <= '0;
            s2_ch     <= '0;
            s3_ch     <= '0;
            s1_mode   <= '0;
            s2_mode   <= '0;
            s3_mode   <= '0;
            s2_val    <= '0;
            s3_val    <= '0;
            for (int unsigned i = 0; i < 9; i++) s1_prod[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (!stall) begin
            s1_v    <= accept && produce;
            s1_ch   <= cur_ch;
            s1_mode <= act_mode;
            s1_prod <= prod_c;
            s2_v    <= s1_v;
            s2_ch   <= s1_ch;
            s2_mode <= s1_mode;
            s2_val  <= s2_c;
            s3_v    <= s2_v;
            s3_ch   <= s2_ch;
            s3_mode <= s2_mode;
            s3_val  <= s3_c;
            out_valid <= s3_v;
            if (s3_v) begin
                out_data <= act;
                out_ch   <= s3_ch;
            end
        end
    end

endmodule

// File: tb/tb_dw_bn_act_engine.sv
// Directed bench: a CH=1 and a CH=4 engine share stimulus; sel4 picks which one is observed.
module tb_dw_bn_act_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [38:0] in_g;
    logic        in_sol, in_valid, cfg_we, out_ready;
    logic [1:0]  act_mode;
    logic [5:0]  cfg_addr;
    logic [12:0] cfg_data;

    logic        rdy1, ov1, rdy4, ov4;
    logic [12:0] od1, od4;
    logic [0:0]  oc1;
    logic [1:0]  oc4;

    logic        sel4;
    logic        rdy, ov;
    logic [12:0] od;
    logic [1:0]  oc;

    int checks = 0;
    int errors = 0;
    int ncount = 0;
    int q_data[$];
    int q_ch[$];
    int q_t[$];
    int last_t, t_ref;

    always #5 clk = ~clk;

    dw_bn_act_engine #(.int_bits(13), .frac_bits(8), .CH(1)) u1 (
        .clk(clk), .reset(reset), .in_g(in_g), .in_sol(in_sol), .in_valid(in_valid),
        .in_ready(rdy1), .act_mode(act_mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr[3:0]),
        .cfg_data(cfg_data), .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(out_ready)
    );

    dw_bn_act_engine #(.int_bits(13), .frac_bits(8), .CH(4)) u4 (
        .clk(clk), .reset(reset), .in_g(in_g), .in_sol(in_sol), .in_valid(in_valid),
        .in_ready(rdy4), .act_mode(act_mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .out_data(od4), .out_ch(oc4), .out_valid(ov4), .out_ready(out_ready)
    );

    always_comb begin
        rdy = sel4 ? rdy4 : rdy1;
        ov  = sel4 ? ov4 : ov1;
        od  = sel4 ? od4 : od1;
        oc  = sel4 ? oc4 : {1'b0, oc1};
    end

    always @(negedge clk) begin
        if (ov && out_ready) begin
            q_data.push_back(int'($signed(od)));
            q_ch.push_back(int'(oc));
            q_t.push_back(ncount);
        end
        ncount++;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qd(input int i);
        return (q_data.size() > i) ? q_data[i] : -99999;
    endfunction

    function automatic int qc(input int i);
        return (q_ch.size() > i) ? q_ch[i] : -99999;
    endfunction

    function automatic int qt(input int i);
        return (q_t.size() > i) ? q_t[i] : -99999;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        q_data.delete();
        q_ch.delete();
        q_t.delete();
    endtask

    task automatic cfg_wr(input int ch, input int slot, input int val);
        cfg_we   = 1'b1;
        cfg_addr = 6'(ch * 16 + slot);
        cfg_data = 13'(val);
        tick;
        cfg_we   = 1'b0;
    endtask

    task automatic set_weights(input int ch, input int val);
        for (int s = 0; s < 9; s++) cfg_wr(ch, s, val);
    endtask

    task automatic beat(input int v, input bit sol, input int mode);
        in_valid = 1'b1;
        in_g     = {3{13'(v)}};
        in_sol   = sol;
        act_mode = 2'(mode);
        last_t   = ncount;
        tick;
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    task automatic drain;
        repeat (8) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_g = '0; in_sol = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        out_ready = 1'b1; act_mode = '0; cfg_addr = '0; cfg_data = '0; sel4 = 1'b0;
        repeat (2) tick;
        chk("rst_valid1", ov1, 0);
        chk("rst_data1", od1, 0);
        chk("rst_ch1", oc1, 0);
        chk("rst_ready1", rdy1, 1);
        chk("rst_valid4", ov4, 0);
        chk("rst_ch4", oc4, 0);
        chk("rst_ready4", rdy4, 1);
        reset = 1'b0;
        tick;

        // basic window, CH=1
        set_weights(0, 256);
        cfg_wr(0, 9, 256);
        clear_q;
        beat(10, 1, 0);
        beat(10, 0, 0);
        beat(10, 0, 0);
        t_ref = last_t;
        drain;
        chk("basic_count", q_data.size(), 1);
        chk("basic_data", qd(0), 90);
        chk("basic_ch", qc(0), 0);
        chk("basic_latency", qt(0) - t_ref, 4);

        // saturation and ReLU6
        set_weights(0, 4095);
        clear_q;
        beat(4095, 1, 0);
        beat(4095, 0, 0);
        beat(4095, 0, 0);
        beat(4095, 0, 2);
        drain;
        chk("sat_count", q_data.size(), 2);
        chk("sat_none", qd(0), 4095);
        chk("sat_relu6", qd(1), 1536);

        // negative results, ReLU, bias, mode 3
        set_weights(0, 256);
        clear_q;
        beat(-10, 1, 0);
        beat(-10, 0, 0);
        beat(-10, 0, 0);
        beat(-10, 0, 1);
        drain;
        cfg_wr(0, 10, 100);
        beat(-10, 0, 1);
        drain;
        cfg_wr(0, 10, 0);
        beat(-10, 0, 3);
        drain;
        chk("neg_count", q_data.size(), 4);
        chk("neg_none", qd(0), -90);
        chk("neg_relu", qd(1), 0);
        chk("neg_relu_bias", qd(2), 10);
        chk("neg_mode3", qd(3), 0);

        // CH=4 interleave
        reset = 1'b1;
        tick;
        reset = 1'b0;
        sel4  = 1'b1;
        tick;
        for (int c = 0; c < 4; c++) begin
            set_weights(c, (c + 1) * 256);
            cfg_wr(c, 9, 256);
        end
        clear_q;
        for (int i = 0; i < 12; i++) begin
            beat(1, i == 0, 0);
            if (i == 8) t_ref = last_t;
        end
        drain;
        chk("ilv_count", q_data.size(), 4);
        for (int c = 0; c < 4; c++) begin
            chk("ilv_data", qd(c), 9 * (c + 1));
            chk("ilv_ch", qc(c), c);
        end
        chk("ilv_latency", qt(0) - t_ref, 4);

        // backpressure: window per channel is {1,1,2} -> 12*(c+1)
        out_ready = 1'b0;
        clear_q;
        for (int i = 0; i < 4; i++) beat(2, 0, 0);
        for (int n = 0; n < 10 && !ov; n++) tick;
        chk("bp_valid_seen", ov, 1);
        in_valid = 1'b1;
        in_g     = {3{13'(100)}};
        for (int n = 0; n < 10; n++) begin
            chk("bp_valid_held", ov, 1);
            chk("bp_data_stable", $signed(od), 12);
            chk("bp_ch_stable", oc, 0);
            chk("bp_ready_low", rdy, 0);
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 6'(15);
        cfg_data  = 13'(1234);
        #1;
        chk("cfg_holds_ready", rdy, 0);
        tick;
        cfg_we = 1'b0;
        drain;
        chk("bp_count", q_data.size(), 4);
        for (int c = 0; c < 4; c++) begin
            chk("bp_data", qd(c), 12 * (c + 1));
            chk("bp_ch", qc(c), c);
        end

        // reset with results in flight
        clear_q;
        for (int i = 0; i < 4; i++) beat(1, 0, 0);
        chk("rst_pre_valid", ov, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_drop_valid", ov, 0);
        chk("rst_drop_data", od, 0);
        tick;
        reset = 1'b0;
        clear_q;
        repeat (10) tick;
        chk("rst_no_leftover", q_data.size(), 0);
        for (int i = 0; i < 12; i++) beat(5, i == 0, 0);
        drain;
        chk("rst_cfg_count", q_data.size(), 4);
        for (int c = 0; c < 4; c++) chk("rst_cfg_zero", qd(c), 0);

        // in_sol on a channel-2 beat resyncs to channel 0, column 0
        set_weights(0, 256);
        cfg_wr(0, 9, 256);
        clear_q;
        beat(7, 1, 0);
        beat(7, 0, 0);
        beat(7, 1, 0);
        for (int i = 0; i < 8; i++) beat(7, 0, 0);
        drain;
        chk("resync_count", q_data.size(), 1);
        chk("resync_data", qd(0), 63);
        chk("resync_ch", qc(0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dw_bn_act_engine.md
# dw_bn_act_engine

Parametrised, channel-interleaved successor to the single-channel depthwise 3×3 / BN / ReLU datapath. It accepts one 3-row input column per beat and keeps a per-channel two-column window history, so the 3×3 window slides horizontally. Each channel has its own weights and BN scale/bias. It adds a selectable activation (none/ReLU/ReLU6), fixed-point rounding with saturation, and valid/ready handshaking with full-pipeline backpressure. It sits between the feature-map formatter and the pointwise stage.

## Interface
- int_bits, 13: signed data, weight and BN word width.
- frac_bits, 8: fractional bits of weights and BN scale.
- CH, 4: number of interleaved channels, 1..16.
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-high. Clears all state.
- in_g  in  3*int_bits: one window column, packed {row2,row1,row0}, signed.
- in_sol  in  1: start of line; qualified by in_valid && in_ready.
- in_valid / in_ready  in / out  1: input handshake.
- act_mode  in  2: 0 none, 1 ReLU, 2 ReLU6, 3 treated as ReLU. Sampled per beat.
- cfg_we  in  1: config write strobe.
- cfg_addr  in  $clog2(CH)+4: {channel, slot}. Slot 0-8 is weight w[r][c] at r*3+c; 9 is BN scale; 10 is BN bias; 11-15 are ignored.
- cfg_data  in  int_bits: config word, signed.
- out_data  out  int_bits: activated result, signed.
- out_ch  out  $clog2(CH) (min 1): channel of out_data.
- out_valid / out_ready  out / in  1: output handshake.

## Operation
- **Beat order:** beat k belongs to channel ch_cnt. ch_cnt wraps from CH-1 to 0, and each wrap increments col_cnt, which saturates at 2.
- **in_sol:** an accepted beat with in_sol=1 forces that beat to channel 0, clears col_cnt to 0 and proceeds. This resyncs a stream whose channel phase has drifted.
- **Window:** per channel, two column registers hold the previous two columns. On each accepted beat the window is {hist1, hist0, in_g}, and the history then shifts.
- **Warm-up:** a beat produces an output only if col_cnt==2 for its channel position. Beats in the first two columns of a line are consumed without producing output.
- **Stage 1:** 9 products of int_bits×int_bits → 2*int_bits signed, registered.
- **Stage 2:** sum of the 9 products (2*int_bits+4 bits), then arithmetic shift right by frac_bits (floor), saturated to int_bits signed [-2^(int_bits-1), 2^(int_bits-1)-1].
- **Stage 3:** BN product = stage2 × scale, shifted right by frac_bits with floor, kept at full width.
- **Stage 4:** the stage-3 result plus bias is saturated to int_bits. Activation is applied: ReLU clamps negatives to 0; ReLU6 additionally clamps to 6<<frac_bits, itself saturated to the max value. The result is registered into out_data.
- **Sideband:** act_mode, channel index and the produce flag travel with the data through the pipeline.
- **Config writes:** take effect the cycle after cfg_we. in_ready is 0 while cfg_we=1, so no beat is ever accepted in the same cycle as a write.
- **Config reset value:** weights, scale and bias reset to 0.

## Timing
- **Reset values:** out_valid=0, out_data=0, out_ch=0, in_ready=1, ch_cnt=0, col_cnt=0, window history 0, config regs 0.
- **Latency:** 4 cycles from an accepted producing beat to out_valid=1, provided there is no stall.
- **Throughput:** 1 beat per cycle.
- **Stall:** stall = out_valid && !out_ready.
  - During stall, all pipeline stages, sideband, ch_cnt, col_cnt and window history hold.
  - in_ready = !stall && !cfg_we, combinational.
  - out_data and out_ch stay stable while out_valid=1 and out_ready=0.
- **Non-producing beats:** warm-up beats and empty slots are bubbles. They never assert out_valid and never stall.
- **Reset mid-stream:** all in-flight results are discarded and out_valid drops immediately. The first accepted beat after reset is channel 0, column 0.
- **Simultaneous in_sol and wrap:** in_sol has priority; ch_cnt is treated as 0 and col_cnt as 0 for that beat.

## Test plan
- **Basic window, CH=1, act_mode=0:** all 9 weights=256, scale=256, bias=0. Feed 3 columns of {10,10,10} with in_sol on the first → one output, out_data=90, 4 cycles after the third beat. The first two beats produce no out_valid.
- **Saturation and ReLU6:** inputs=4095, weights=4095, scale=256 → out_data=4095 with act_mode=0, and 1536 with act_mode=2.
- **Negative result:** inputs={-10,-10,-10} with the weights from the first scenario, bias=0 → out_data=-90 with mode 0, and 0 with mode 1. Repeat with bias=100 in mode 1 → 10.
- **CH=4 interleave:** weights for channel c are all (c+1)*256. Feed 12 beats of value 1 → outputs on beats 9-12 of 9, 18, 27, 36, with out_ch=0,1,2,3.
- **Backpressure:** hold out_ready=0 for 10 cycles in mid-stream. Required: in_ready=0 throughout, out_data stable, and no output lost or duplicated after release. A simultaneous cfg_we also holds in_ready=0.
- **Reset and resync:**
  - Assert reset with 3 results in flight → out_valid=0 immediately, and nothing emerges afterwards. Config reads back as zeros, so a subsequent stream gives 0.
  - Separately, in_sol on a channel-2 beat → that beat is treated as channel 0, column 0.
